// File: rtl/cnn_layer_accel_job_sequencer.sv
// Job sequencer for one cnn_layer_accel_quad: writes config slots, launches the job,
// brokers quad fetch requests to an external fetch engine and acknowledges completion.
module cnn_layer_accel_job_sequencer #(
    parameter int unsigned C_TIMEOUT_CYCLES = 65536,
    parameter int unsigned C_JOB_CNT_WIDTH  = 16
) (
    input  logic                       clk_if,
    input  logic                       rst,
    input  logic                       desc_valid,
    output logic                       desc_ready,
    input  logic [127:0]               desc_params,
    input  logic [3:0]                 desc_cfg_mask,
    input  logic [511:0]               desc_cfg_data,
    output logic [3:0]                 config_valid,
    input  logic [3:0]                 config_accept,
    output logic [127:0]               config_data,
    output logic                       job_start,
    input  logic                       job_accept,
    output logic [127:0]               job_parameters,
    input  logic                       job_fetch_request,
    output logic                       job_fetch_ack,
    output logic                       job_fetch_complete,
    input  logic                       job_complete,
    output logic                       job_complete_ack,
    output logic                       fetch_go,
    input  logic                       fetch_done,
    output logic                       busy,
    output logic                       error,
    input  logic                       err_clear,
    output logic [C_JOB_CNT_WIDTH-1:0] jobs_done
);

    localparam int unsigned WdWidth = $clog2(C_TIMEOUT_CYCLES);
    localparam logic [WdWidth-1:0] WdLast = WdWidth'(C_TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        StIdle,
        StConfig,
        StStart,
        StFetchWait,
        StFetchAck,
        StFetchRun,
        StFetchDone,
        StRun,
        StCmplAck,
        StError
    } state_e;

    state_e                     state_q, state_d;
    logic [WdWidth-1:0]         wd_q, wd_d;
    logic [1:0]                 slot_q, slot_d;
    logic [3:0]                 mask_q, mask_d;
    logic [127:0]               params_q, params_d;
    logic [3:0][127:0]          data_q, data_d;
    logic [C_JOB_CNT_WIDTH-1:0] jobs_q, jobs_d;
    logic [2:0]                 hit;
    logic                       slot_adv;
    logic                       waiting;

    logic         desc_ready_q, desc_ready_d;
    logic [3:0]   config_valid_q, config_valid_d;
    logic [127:0] config_data_q, config_data_d;
    logic         job_start_q, job_start_d;
    logic [127:0] job_parameters_q, job_parameters_d;
    logic         job_fetch_ack_q, job_fetch_ack_d;
    logic         job_fetch_complete_q, job_fetch_complete_d;
    logic         job_complete_ack_q, job_complete_ack_d;
    logic         fetch_go_q, fetch_go_d;
    logic         busy_q, busy_d;
    logic         error_q, error_d;

    // {found, index} of the lowest set bit
    function automatic logic [2:0] lowest_set(input logic [3:0] m);
        logic [2:0] r;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) r = {1'b1, 2'(k)};
        end
        return r;
    endfunction

    always_ff @(posedge clk_if) begin
        if (!rst) begin
            state_q              <= StIdle;
            wd_q                 <= '0;
            slot_q               <= '0;
            mask_q               <= '0;
            params_q             <= '0;
            data_q               <= '0;
            jobs_q               <= '0;
            desc_ready_q         <= 1'b0;
            config_valid_q       <= '0;
            config_data_q        <= '0;
            job_start_q          <= 1'b0;
            job_parameters_q     <= '0;
            job_fetch_ack_q      <= 1'b0;
            job_fetch_complete_q <= 1'b0;
            job_complete_ack_q   <= 1'b0;
            fetch_go_q           <= 1'b0;
            busy_q               <= 1'b0;
            error_q              <= 1'b0;
        end else begin
            state_q              <= state_d;
            wd_q                 <= wd_d;
            slot_q               <= slot_d;
            mask_q               <= mask_d;
            params_q             <= params_d;
            data_q               <= data_d;
            jobs_q               <= jobs_d;
            desc_ready_q         <= desc_ready_d;
            config_valid_q       <= config_valid_d;
            config_data_q        <= config_data_d;
            job_start_q          <= job_start_d;
            job_parameters_q     <= job_parameters_d;
            job_fetch_ack_q      <= job_fetch_ack_d;
            job_fetch_complete_q <= job_fetch_complete_d;
            job_complete_ack_q   <= job_complete_ack_d;
            fetch_go_q           <= fetch_go_d;
            busy_q               <= busy_d;
            error_q              <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        mask_d   = mask_q;
        params_d = params_q;
        data_d   = data_q;
        jobs_d   = jobs_q;
        wd_d     = '0;
        hit      = 3'b000;
        slot_adv = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (desc_valid && desc_ready_q) begin
                    params_d = desc_params;
                    mask_d   = desc_cfg_mask;
                    data_d   = desc_cfg_data;
                    hit      = lowest_set(desc_cfg_mask);
                    if (hit[2]) begin
                        state_d = StConfig;
                        slot_d  = hit[1:0];
                    end else begin
                        state_d = StStart;
                    end
                end
            end
            StConfig: begin
                if (config_accept[slot_q]) begin
                    hit = lowest_set(mask_q & 4'(4'b1110 << slot_q));
                    if (hit[2]) begin
                        slot_d   = hit[1:0];
                        slot_adv = 1'b1;
                    end else begin
                        state_d = StStart;
                    end
                end
            end
            StStart:     if (job_accept) state_d = StFetchWait;
            StFetchWait, StRun: begin
                if (job_complete)           state_d = StCmplAck;
                else if (job_fetch_request) state_d = StFetchAck;
            end
            StFetchAck:  state_d = StFetchRun;
            StFetchRun:  if (fetch_done) state_d = StFetchDone;
            StFetchDone: state_d = StRun;
            StCmplAck:   state_d = StIdle;
            StError:     if (err_clear) state_d = StIdle;
            default:     state_d = StIdle;
        endcase

        // A slot handover counts as progress; only a genuine stall ages the watchdog.
        waiting = state_q inside {StConfig, StStart, StFetchWait, StFetchRun, StRun};
        if (waiting && (state_d == state_q) && !slot_adv) begin
            if (wd_q == WdLast) state_d = StError;
            else                wd_d    = wd_q + WdWidth'(1);
        end

        if (state_d == StCmplAck) jobs_d = jobs_q + C_JOB_CNT_WIDTH'(1);
    end

    // Outputs are decoded from the next state so they register on the deciding edge.
    always_comb begin
        desc_ready_d         = (state_d == StIdle);
        config_valid_d       = '0;
        config_data_d        = '0;
        if (state_d == StConfig) begin
            config_valid_d = 4'b0001 << slot_d;
            config_data_d  = data_d[slot_d];
        end
        job_start_d          = (state_d == StStart);
        job_parameters_d     = (state_d == StStart) ? params_d : '0;
        job_fetch_ack_d      = (state_d == StFetchAck);
        fetch_go_d           = (state_d == StFetchAck);
        job_fetch_complete_d = (state_d == StFetchDone);
        job_complete_ack_d   = (state_d == StCmplAck);
        busy_d               = (state_d != StIdle) && (state_d != StError);
        error_d              = (state_d == StError);
    end

    assign desc_ready         = desc_ready_q;
    assign config_valid       = config_valid_q;
    assign config_data        = config_data_q;
    assign job_start          = job_start_q;
    assign job_parameters     = job_parameters_q;
    assign job_fetch_ack      = job_fetch_ack_q;
    assign job_fetch_complete = job_fetch_complete_q;
    assign job_complete_ack   = job_complete_ack_q;
    assign fetch_go           = fetch_go_q;
    assign busy               = busy_q;
    assign error              = error_q;
    assign jobs_done          = jobs_q;

endmodule
